instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch front end that produces the `Ins`/`en` stream consumed by `control_unit`. It holds the program counter and issues word-aligned requests to instruction memory over a request/grant, in-order-response handshake. Returned words are buffered in a small FIFO and presented to the decoder. It takes the decoder's `Branch` redirect and flushes any wrong-path fetches.

## Interface

- `RESET_PC`, 32'h0000_0000, PC fetched first after reset; bits [1:0] are forced to 0.
- `FIFO_DEPTH`, 2, instruction buffer depth; legal values are 2, 4 or 8. It also caps outstanding requests.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, word-aligned.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; exactly one response per grant, in order, at least 1 cycle after the grant.
- `imem_rdata`  in  32  response instruction word.
- `Ins`  out  32  instruction to `control_unit`.
- `en`  out  1  `Ins` valid; drives `control_unit.en`.
- `pc_out`  out  32  PC of the current `Ins`.
- `stall`  in  1  downstream hold; while high, `Ins`/`en`/`pc_out` do not advance.
- `Branch`  in  1  redirect request (from `control_unit`).
- `branch_target`  in  32  redirect PC; bits [1:0] are ignored.

## Operation

- State: `fetch_pc`, outstanding counter `outs` (0..FIFO_DEPTH), drop counter `drop`, and a FIFO of {pc, word} entries with count `cnt`.
- FSM states:
  - RUN: normal operation.
  - FLUSH: `drop` > 0; stale responses are discarded.
  - FLUSH returns to RUN when `drop` reaches 0.
- Request issue: `imem_req` = (`outs` + `cnt` < FIFO_DEPTH) and not `Branch`. `imem_addr` = `fetch_pc`.
- On grant (`imem_req` & `imem_gnt`): the FIFO slot is reserved, `outs` increments, and `fetch_pc` += 4 (wraps modulo 2^32).
- Handshake rules:
  - `imem_req` and `imem_addr` stay stable until granted.
  - The only exception is a redirect, which may withdraw or change a pending request.
- Response handling:
  - In RUN: `imem_rvalid` pushes {pc, `imem_rdata`} and `outs` decrements.
  - In FLUSH: the response is discarded, `drop` decrements and `outs` decrements.
  - The pushed pc is the PC of the oldest in-flight request, tracked in a parallel PC queue or by a base-plus-count scheme.
- Output:
  - `en` = `cnt` != 0.
  - `Ins` and `pc_out` are the FIFO head.
  - When `en` = 0: `Ins` = 32'h0000_0013 (NOP) and `pc_out` holds its last value.
- Pop: when `en` & ~`stall`.
- Redirect (`Branch` = 1 in any cycle):
  - FIFO is cleared.
  - `fetch_pc` <= {`branch_target`[31:2], 2'b00}.
  - `drop` <= the number of responses still owed after this cycle's `imem_rvalid`. Any grant in this cycle is impossible because `imem_req` is 0.
  - Go to FLUSH if `drop` > 0, otherwise RUN.
  - A response arriving in the same cycle as `Branch` is discarded.
- `Branch` during FLUSH recomputes `drop` by the same rule. Stale responses are never delivered.
- Redirect has priority over pop, push and `stall`.

## Timing

- Reset values, asynchronous:
  - `imem_req` = 0, `imem_addr` = RESET_PC.
  - `en` = 0, `Ins` = 32'h0000_0013, `pc_out` = RESET_PC.
  - `outs` = `drop` = `cnt` = 0, state RUN.
- First `imem_req` = 1 in the first cycle after `rst` falls.
- Latency: a response with `imem_rvalid` at edge N gives `en` = 1 with that word after edge N. There is no bypass.
- Redirect latency:
  - `en` = 0 in the cycle after `Branch`.
  - The target request is issued in the cycle after `Branch`.
- Full: when `outs` + `cnt` = FIFO_DEPTH, `imem_req` = 0. It reasserts the cycle after a pop or a redirect.
- Empty with `stall` = 1: `en` stays 0 and nothing is popped.
- `rst` mid-transaction: all state clears immediately. Responses owed to pre-reset requests are the memory's responsibility and are not tracked.

## Test plan

- Reset and stream:
  - Stimulus: `rst` 1→0, `imem_gnt` = 1, responses 1 cycle after grant with words 32'h415A04B3, 32'h015A0493, 32'h015A14B3.
  - Required: addresses 0x0, 0x4, 0x8 in order; `en` high with those words; `pc_out` = 0x0, 0x4, 0x8.
- Backpressure:
  - Stimulus: `stall` = 1 with FIFO_DEPTH = 2.
  - Required: after 2 grants `imem_req` = 0; `Ins` holds 32'h415A04B3. Dropping `stall` pops one entry per cycle and `imem_req` reasserts.
- Redirect with in-flight responses:
  - Stimulus: 2 requests outstanding, `Branch` = 1 with `branch_target` = 32'h0000_0103.
  - Required: both stale responses are discarded; the next address is 0x100; the first `en` shows `pc_out` = 0x100.
- Simultaneous events:
  - Stimulus: `Branch` and `imem_rvalid` in the same cycle.
  - Required: that word is never presented. `Branch` again during FLUSH: only target-2 words are delivered.
- Grant stall:
  - Stimulus: `imem_gnt` = 0 for 5 cycles.
  - Required: `imem_req` = 1 and `imem_addr` stable throughout; `fetch_pc` does not advance.
- Reset mid-operation:
  - Stimulus: `rst` pulse with a full FIFO.
  - Required: `en` = 0, `Ins` = 32'h00000013 and `imem_addr` = RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, request/grant memory handshake,
// in-order response buffering and branch redirect with stale-response flushing.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Ins,
    output logic        en,
    output logic [31:0] pc_out,
    input  logic        stall,
    input  logic        Branch,
    input  logic [31:0] branch_target
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_INIT  = RESET_PC & 32'hFFFF_FFFC;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outs_q,     outs_d;
    logic [CNT_W-1:0] drop_q,     drop_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [31:0]      last_pc_q;

    logic [31:0] word_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];

    logic             grant;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] live;
    logic [31:0]      resp_pc;
    logic [31:0]      target_pc;

    // Requests are capped so every in-flight word already owns a buffer slot.
    assign imem_req  = ~rst & ~Branch &
                       ((SUM_W'(outs_q) + SUM_W'(cnt_q)) < SUM_W'(FIFO_DEPTH));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req & imem_gnt;

    // Oldest live request PC: fetch_pc minus the live (non-stale) in-flight count.
    assign live      = outs_q - drop_q;
    assign resp_pc   = fetch_pc_q - (32'(live) << 2);
    assign target_pc = branch_target & 32'hFFFF_FFFC;

    assign push   = imem_rvalid & ~Branch & (state_q == ST_RUN);
    assign en     = (cnt_q != '0);
    assign pop    = en & ~stall & ~Branch;
    assign Ins    = en ? word_mem[rd_ptr_q] : NOP_INSN;
    assign pc_out = en ? pc_mem[rd_ptr_q] : last_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outs_d     = outs_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (grant) begin
            outs_d     = outs_d + CNT_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (imem_rvalid && (outs_q != '0)) begin
            outs_d = outs_d - CNT_W'(1);
        end

        if (Branch) begin
            // Everything still owed after this cycle belongs to the wrong path.
            fetch_pc_d = target_pc;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = outs_d;
            state_d    = (outs_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (imem_rvalid) begin
                        drop_d = drop_q - CNT_W'(1);
                        if (drop_q == CNT_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= PC_INIT;
            outs_q     <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_pc_q  <= PC_INIT;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_pc_q  <= pc_out;
        end
    end

    // Buffer storage needs no reset; validity is carried by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= resp_pc;
        end
    end

endmodule
